// File: rtl/store_size_ctrl.sv
// Store-path controller for sw/sh/sb. Word stores write directly; halfword and
// byte stores read the containing word, merge the new lane in and write it back.
module store_size_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_wr_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        exc_o
);

    localparam logic [1:0] SizeWord = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeByte = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StDone
    } state_e;

    state_e      state_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] rs_q;
    logic        err_q;
    logic [31:0] merge_q;
    logic [31:0] merge_d;
    logic [31:0] wdata_q;

    // Merge the latched register value into the word returned by memory.
    always_comb begin
        merge_d = mem_rdata_i;
        case (size_q)
            SizeWord: merge_d = rs_q;
            SizeHalf: begin
                if (addr_q[1]) begin
                    merge_d[31:16] = rs_q[15:0];
                end else begin
                    merge_d[15:0] = rs_q[15:0];
                end
            end
            SizeByte: begin
                unique case (addr_q[1:0])
                    2'b00: merge_d[7:0]   = rs_q[7:0];
                    2'b01: merge_d[15:8]  = rs_q[7:0];
                    2'b10: merge_d[23:16] = rs_q[7:0];
                    2'b11: merge_d[31:24] = rs_q[7:0];
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Store sequencing FSM with request latching and write-data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            rs_q    <= 32'h0;
            err_q   <= 1'b0;
            merge_q <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        size_q <= size_i;
                        addr_q <= addr_i;
                        rs_q   <= rs_data_i;
                        if (size_i == SizeWord) begin
                            err_q   <= 1'b0;
                            wdata_q <= rs_data_i;
                            state_q <= StWrite;
                        end else if ((size_i == SizeHalf && !addr_i[0]) ||
                                     size_i == SizeByte) begin
                            err_q   <= 1'b0;
                            state_q <= StRead;
                        end else begin
                            // Misaligned halfword or reserved size: no memory access.
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StRead: state_q <= StWait;
                StWait: begin
                    // Read data is valid this cycle; capture the merged word.
                    merge_q <= merge_d;
                    wdata_q <= merge_d;
                    state_q <= StWrite;
                end
                StWrite: state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_wdata_o = wdata_q;
    assign mem_wr_o    = (state_q == StWrite);
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign exc_o       = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_store_size_ctrl.sv
// Self-checking bench for store_size_ctrl: memory model, directed and random stores.
module tb_store_size_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] rs_data;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        exc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        ld_en;
    logic [7:0]  ld_idx;
    logic [31:0] ld_val;
    logic [31:0] last_wdata;

    always #5 clk = ~clk;

    store_size_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .size_i      (size),
        .addr_i      (addr),
        .rs_data_i   (rs_data),
        .mem_rdata_i (mem_rdata),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wr_o    (mem_wr),
        .busy_o      (busy),
        .done_o      (done),
        .exc_o       (exc)
    );

    // Word memory: one-cycle read latency, write on mem_wr, bench preload port.
    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[9:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        ld_en  = 1'b1;
        ld_idx = idx[7:0];
        ld_val = val;
        ref_mem[idx] = val;
        step();
        ld_en = 1'b0;
    endtask

    // Reference result of a store: overwrite the addressed little-endian bytes.
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] d);
        logic [7:0]  b [4];
        logic [31:0] r;
        int          nbytes;
        int          base;
        if (sz == 2'b00) return d;
        for (int k = 0; k < 4; k++) b[k] = old[8*k +: 8];
        nbytes = (sz == 2'b01) ? 2 : 1;
        base   = int'(a[1:0]);
        for (int k = 0; k < nbytes; k++) b[base + k] = d[8*k +: 8];
        for (int k = 0; k < 4; k++) r[8*k +: 8] = b[k];
        return r;
    endfunction

    // Issue one store, observe 8 cycles, and compare against the model.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input int cut_in_cyc);
        bit          err;
        int          exp_wr;
        int          exp_done;
        int          idx;
        logic [31:0] exp_word;
        logic [31:0] waddr;
        int          wr_cnt = 0;
        int          wr_cyc = 0;
        int          done_cnt = 0;
        int          done_cyc = 0;
        int          exc_cnt = 0;
        logic        exc_at_done = 1'b0;
        logic [31:0] wdata_at_wr = 32'h0;
        logic [31:0] addr_at_wr = 32'h0;
        logic [31:0] addr_c1 = 32'h0;
        logic        busy_at [0:9];

        err      = (sz == 2'b11) || (sz == 2'b01 && a[0]);
        exp_wr   = err ? 0 : ((sz == 2'b00) ? 1 : 3);
        exp_done = err ? 1 : ((sz == 2'b00) ? 2 : 4);
        idx      = int'(a[9:2]);
        waddr    = {a[31:2], 2'b00};
        exp_word = ref_merge(ref_mem[idx], sz, a, d);
        for (int c = 0; c < 10; c++) busy_at[c] = 1'b0;

        start = 1'b1; size = sz; addr = a; rs_data = d;
        for (int c = 1; c <= 8; c++) begin
            step();
            start = 1'b0; size = 2'($urandom); addr = $urandom; rs_data = $urandom;
            if (c == cut_in_cyc) start = 1'b1;
            busy_at[c] = busy;
            if (c == 1) addr_c1 = mem_addr;
            if (mem_wr) begin
                wr_cnt++; wr_cyc = c; wdata_at_wr = mem_wdata; addr_at_wr = mem_addr;
            end
            if (done) begin
                done_cnt++; done_cyc = c; exc_at_done = exc;
            end
            if (exc) exc_cnt++;
        end
        start = 1'b0;

        check("done_cycle", done_cyc, exp_done);
        check("done_count", done_cnt, 1);
        check("exc_at_done", {31'h0, exc_at_done}, {31'h0, err});
        check("exc_count", exc_cnt, err ? 1 : 0);
        check("write_count", wr_cnt, err ? 0 : 1);
        check("busy_last", {31'h0, busy_at[exp_done]}, 32'h1);
        check("busy_drop", {31'h0, busy_at[exp_done + 1]}, 32'h0);
        if (!err) begin
            check("write_cycle", wr_cyc, exp_wr);
            check("write_data", wdata_at_wr, exp_word);
            check("write_addr", addr_at_wr, waddr);
            ref_mem[idx] = exp_word;
        end
        if (!err && sz != 2'b00) check("read_addr", addr_c1, waddr);
        last_wdata = wdata_at_wr;
    endtask

    initial begin
        int done_seen;
        int wr_seen;
        reset = 1'b1; start = 1'b0; size = 2'b00; addr = 32'h0; rs_data = 32'h0;
        ld_en = 1'b0; ld_idx = 8'h0; ld_val = 32'h0; last_wdata = 32'h0;

        for (int i = 0; i < 256; i++) preload(i, $urandom);

        // Reset state
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_ctrl", {28'h0, mem_wr, busy, done, exc}, 32'h0);
        reset = 1'b0;
        step();

        // sw
        do_store(2'b00, 32'h304, 32'hA5A5A5A5, 0);
        check("sw_plan", last_wdata, 32'hA5A5A5A5);

        // sb
        preload(32'h100 >> 2, 32'hDEADBEEF);
        do_store(2'b10, 32'h102, 32'h123456AB, 0);
        check("sb_plan", last_wdata, 32'hDEABBEEF);

        // sh upper and lower half
        preload(32'h200 >> 2, 32'h11223344);
        do_store(2'b01, 32'h202, 32'h0000CAFE, 0);
        check("sh_hi_plan", last_wdata, 32'hCAFE3344);
        preload(32'h200 >> 2, 32'h11223344);
        do_store(2'b01, 32'h200, 32'h0000CAFE, 0);
        check("sh_lo_plan", last_wdata, 32'h1122CAFE);

        // Misaligned halfword and reserved size
        do_store(2'b01, 32'h203, 32'h12345678, 0);
        do_store(2'b11, 32'h0, 32'h87654321, 0);

        // Second start while busy is ignored
        do_store(2'b10, 32'h011, 32'h00000055, 2);

        // Reset during WAIT of a byte store
        start = 1'b1; size = 2'b10; addr = 32'h21; rs_data = 32'h77;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_wait_mem_addr", mem_addr, 32'h0);
        check("rst_wait_mem_wdata", mem_wdata, 32'h0);
        check("rst_wait_ctrl", {28'h0, mem_wr, busy, done, exc}, 32'h0);
        done_seen = 0; wr_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) done_seen++;
            if (mem_wr) wr_seen++;
            step();
        end
        check("rst_wait_no_done", done_seen, 0);
        check("rst_wait_no_write", wr_seen, 0);
        check("rst_wait_mem_kept", mem[32'h20 >> 2], ref_mem[32'h20 >> 2]);
        do_store(2'b00, 32'h040, 32'hC0FFEE01, 0);

        // Random stores
        for (int i = 0; i < 24; i++) begin
            do_store(2'($urandom), {22'h0, 10'($urandom)}, $urandom, 0);
        end
        for (int i = 0; i < 256; i += 37) check("final_mem", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
